// File: rtl/mmio_decoder.sv
// Address decoder between the core data port and N_SLAVES peripheral windows.
// Gates strobes to the selected slave, stalls on not-ready with a timeout, and records faults.
module mmio_decoder #(
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32,
  parameter int N_SLAVES = 4,
  parameter logic [N_SLAVES*ADDR_W-1:0] SLAVE_BASE =
    {32'h0000_4010, 32'h0000_4008, 32'h0000_4000, 32'h0000_0000},
  parameter logic [N_SLAVES*ADDR_W-1:0] SLAVE_SIZE =
    {32'h8, 32'h8, 32'h4, 32'h4000},
  parameter int WAIT_LIMIT = 15
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [ADDR_W-1:0]          cpu_addr,
  input  logic [DATA_W-1:0]          cpu_wdata,
  input  logic                       cpu_read,
  input  logic                       cpu_write,
  output logic                       cpu_stall,
  output logic [DATA_W-1:0]          cpu_rdata,
  output logic                       cpu_rvalid,
  output logic                       cpu_fault,
  output logic [ADDR_W-1:0]          fault_addr,
  output logic [7:0]                 fault_count,
  output logic [N_SLAVES-1:0]        s_sel,
  output logic                       s_read,
  output logic                       s_write,
  output logic [ADDR_W-1:0]          s_offset,
  output logic [DATA_W-1:0]          s_wdata,
  input  logic [N_SLAVES-1:0]        s_ready,
  input  logic [N_SLAVES*DATA_W-1:0] s_rdata
);

  localparam int IDX_W = (N_SLAVES > 1) ? $clog2(N_SLAVES) : 1;
  localparam logic [7:0] WAIT_LIMIT_C = 8'(WAIT_LIMIT);

  typedef enum logic {ST_IDLE, ST_WAIT} state_e;

  state_e             state_q, state_d;
  logic [7:0]         wait_cnt_q, wait_cnt_d;
  logic               rvalid_q;
  logic [IDX_W-1:0]   rd_idx_q;
  logic               fault_q;
  logic [ADDR_W-1:0]  fault_addr_q;
  logic [7:0]         fault_cnt_q;

  logic [N_SLAVES-1:0] hit_vec;
  logic [IDX_W-1:0]    win_idx;
  logic                any_hit;
  logic [ADDR_W-1:0]   sel_base;
  logic                sel_ready;
  logic                req, illegal, valid_acc, fault_event;
  logic                strobe, abort, stall;
  logic [DATA_W-1:0]   rdata_mux;

  // Window compare is one bit wider so a window ending at the top of the space cannot wrap.
  genvar gi;
  generate
    for (gi = 0; gi < N_SLAVES; gi++) begin : g_win
      logic [ADDR_W:0] base_x, limit_x, addr_x;
      assign base_x       = {1'b0, SLAVE_BASE[gi*ADDR_W +: ADDR_W]};
      assign limit_x      = base_x + {1'b0, SLAVE_SIZE[gi*ADDR_W +: ADDR_W]};
      assign addr_x       = {1'b0, cpu_addr};
      assign hit_vec[gi]  = (addr_x >= base_x) && (addr_x < limit_x);
      assign s_sel[gi]    = req && any_hit && (win_idx == IDX_W'(gi));
    end
  endgenerate

  // Scanning downward leaves the lowest-index hit as the winner on overlaps.
  always_comb begin
    win_idx   = '0;
    any_hit   = 1'b0;
    sel_base  = '0;
    sel_ready = 1'b0;
    for (int i = N_SLAVES - 1; i >= 0; i--) begin
      if (hit_vec[i]) begin
        win_idx   = IDX_W'(i);
        any_hit   = 1'b1;
        sel_base  = SLAVE_BASE[i*ADDR_W +: ADDR_W];
        sel_ready = s_ready[i];
      end
    end
  end

  assign req         = cpu_read | cpu_write;
  assign illegal     = cpu_read & cpu_write;
  assign valid_acc   = req & ~illegal & any_hit;
  assign fault_event = (req & ~valid_acc) | abort;

  // IDLE and WAIT share one decision path; the wait counter is zero in IDLE.
  always_comb begin
    state_d    = ST_IDLE;
    wait_cnt_d = '0;
    strobe     = 1'b0;
    abort      = 1'b0;
    stall      = 1'b0;
    if (valid_acc) begin
      if (sel_ready) begin
        strobe = 1'b1;
      end else if (state_q == ST_WAIT && wait_cnt_q == WAIT_LIMIT_C) begin
        abort = 1'b1;
      end else begin
        stall      = 1'b1;
        state_d    = ST_WAIT;
        wait_cnt_d = wait_cnt_q + 8'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      wait_cnt_q   <= '0;
      rvalid_q     <= 1'b0;
      rd_idx_q     <= '0;
      fault_q      <= 1'b0;
      fault_addr_q <= '0;
      fault_cnt_q  <= '0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      rvalid_q   <= s_read;
      fault_q    <= fault_event;
      if (s_read) begin
        rd_idx_q <= win_idx;
      end
      if (fault_event) begin
        fault_addr_q <= cpu_addr;
        if (fault_cnt_q != 8'hFF) begin
          fault_cnt_q <= fault_cnt_q + 8'd1;
        end
      end
    end
  end

  always_comb begin
    rdata_mux = '0;
    for (int i = 0; i < N_SLAVES; i++) begin
      if (rd_idx_q == IDX_W'(i)) begin
        rdata_mux = s_rdata[i*DATA_W +: DATA_W];
      end
    end
  end

  assign s_read      = strobe & cpu_read;
  assign s_write     = strobe & cpu_write;
  assign s_offset    = any_hit ? (cpu_addr - sel_base) : '0;
  assign s_wdata     = cpu_wdata;
  assign cpu_stall   = stall;
  assign cpu_rvalid  = rvalid_q;
  assign cpu_rdata   = rvalid_q ? rdata_mux : '0;
  assign cpu_fault   = fault_q;
  assign fault_addr  = fault_addr_q;
  assign fault_count = fault_cnt_q;

endmodule

// File: tb/tb_mmio_decoder.sv
// Bench for mmio_decoder: directed scenarios plus a randomized run against a window-table model.
module tb_mmio_decoder;

  localparam int N = 4;
  localparam int LIMIT = 15;
  localparam logic [31:0] M_BASE [N] = '{32'h0, 32'h4000, 32'h4008, 32'h4010};
  localparam logic [31:0] M_SIZE [N] = '{32'h4000, 32'h4, 32'h8, 32'h8};

  logic          clk = 1'b0;
  logic          rst;
  logic [31:0]   cpu_addr, cpu_wdata;
  logic          cpu_read, cpu_write;
  logic          cpu_stall, cpu_rvalid, cpu_fault;
  logic [31:0]   cpu_rdata, fault_addr;
  logic [7:0]    fault_count;
  logic [N-1:0]  s_sel, s_ready;
  logic          s_read, s_write;
  logic [31:0]   s_offset, s_wdata;
  logic [N*32-1:0] s_rdata;

  int n_checks = 0;
  int n_errors = 0;
  int exp_cnt  = 0;

  always #5 clk = ~clk;

  mmio_decoder dut (
    .clk(clk), .rst(rst),
    .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_read(cpu_read), .cpu_write(cpu_write),
    .cpu_stall(cpu_stall), .cpu_rdata(cpu_rdata), .cpu_rvalid(cpu_rvalid),
    .cpu_fault(cpu_fault), .fault_addr(fault_addr), .fault_count(fault_count),
    .s_sel(s_sel), .s_read(s_read), .s_write(s_write),
    .s_offset(s_offset), .s_wdata(s_wdata),
    .s_ready(s_ready), .s_rdata(s_rdata)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic rd, input logic wr, input logic [31:0] a, input logic [N-1:0] rdy);
    cpu_read  = rd;
    cpu_write = wr;
    cpu_addr  = a;
    s_ready   = rdy;
    #1;
  endtask

  // Lowest-index window containing the address, computed with wide arithmetic.
  function automatic int decode(input logic [31:0] a);
    longint unsigned la, lb, ls;
    decode = -1;
    la = 64'(a);
    for (int i = N - 1; i >= 0; i--) begin
      lb = 64'(M_BASE[i]);
      ls = 64'(M_SIZE[i]);
      if (la >= lb && la < lb + ls) decode = i;
    end
  endfunction

  task automatic test_reset();
    rst = 1'b1;
    cpu_wdata = 32'h0;
    s_rdata = '0;
    drive(1'b0, 1'b0, 32'h0, 4'hF);
    tick();
    tick();
    rst = 1'b0;
    #1;
    n_checks++; if (cpu_stall !== 1'b0) begin n_errors++; $display("FAIL reset_stall got=%b exp=0", cpu_stall); end
    n_checks++; if (cpu_rvalid !== 1'b0) begin n_errors++; $display("FAIL reset_rvalid got=%b exp=0", cpu_rvalid); end
    n_checks++; if (cpu_rdata !== 32'h0) begin n_errors++; $display("FAIL reset_rdata got=%h exp=0", cpu_rdata); end
    n_checks++; if (cpu_fault !== 1'b0) begin n_errors++; $display("FAIL reset_fault got=%b exp=0", cpu_fault); end
    n_checks++; if (fault_addr !== 32'h0) begin n_errors++; $display("FAIL reset_faddr got=%h exp=0", fault_addr); end
    n_checks++; if (fault_count !== 8'h0) begin n_errors++; $display("FAIL reset_fcount got=%0d exp=0", fault_count); end
    n_checks++; if (s_sel !== 4'h0) begin n_errors++; $display("FAIL reset_sel got=%b exp=0000", s_sel); end
    exp_cnt = 0;
    $display("reset: released");
  endtask

  task automatic test_write();
    logic [31:0] wd;
    wd = $urandom;
    cpu_wdata = wd;
    drive(1'b0, 1'b1, 32'h0000_0100, 4'hF);
    n_checks++; if (s_sel !== 4'b0001) begin n_errors++; $display("FAIL wr_sel got=%b exp=0001", s_sel); end
    n_checks++; if (s_write !== 1'b1 || s_read !== 1'b0) begin n_errors++; $display("FAIL wr_strobe got=w%b r%b exp=w1 r0", s_write, s_read); end
    n_checks++; if (s_offset !== 32'h100) begin n_errors++; $display("FAIL wr_offset got=%h exp=100", s_offset); end
    n_checks++; if (cpu_stall !== 1'b0) begin n_errors++; $display("FAIL wr_stall got=%b exp=0", cpu_stall); end
    n_checks++; if (s_wdata !== wd) begin n_errors++; $display("FAIL wr_wdata got=%h exp=%h", s_wdata, wd); end
    tick();
    drive(1'b0, 1'b0, 32'h0, 4'hF);
    n_checks++; if (cpu_fault !== 1'b0 || cpu_rvalid !== 1'b0) begin n_errors++; $display("FAIL wr_after got=f%b v%b exp=f0 v0", cpu_fault, cpu_rvalid); end
    $display("write: addr=00000100 data=%h", wd);
  endtask

  task automatic test_read();
    s_rdata = {$urandom, $urandom, 32'h41, $urandom};
    drive(1'b1, 1'b0, 32'h0000_4000, 4'hF);
    n_checks++; if (s_sel !== 4'b0010) begin n_errors++; $display("FAIL rd_sel got=%b exp=0010", s_sel); end
    n_checks++; if (s_offset !== 32'h0) begin n_errors++; $display("FAIL rd_offset got=%h exp=0", s_offset); end
    n_checks++; if (s_read !== 1'b1 || cpu_stall !== 1'b0) begin n_errors++; $display("FAIL rd_strobe got=r%b s%b exp=r1 s0", s_read, cpu_stall); end
    tick();
    drive(1'b0, 1'b0, 32'h0, 4'hF);
    n_checks++; if (cpu_rvalid !== 1'b1) begin n_errors++; $display("FAIL rd_rvalid got=%b exp=1", cpu_rvalid); end
    n_checks++; if (cpu_rdata !== 32'h41) begin n_errors++; $display("FAIL rd_rdata got=%h exp=41", cpu_rdata); end
    tick();
    n_checks++; if (cpu_rvalid !== 1'b0 || cpu_rdata !== 32'h0) begin n_errors++; $display("FAIL rd_idle got=v%b d%h exp=v0 d0", cpu_rvalid, cpu_rdata); end
    $display("read: addr=00004000 data=00000041");
  endtask

  task automatic test_stall();
    cpu_wdata = $urandom;
    for (int c = 0; c < 3; c++) begin
      drive(1'b0, 1'b1, 32'h0000_4000, 4'b1101);
      n_checks++; if (cpu_stall !== 1'b1 || s_write !== 1'b0) begin n_errors++; $display("FAIL stall_c%0d got=s%b w%b exp=s1 w0", c, cpu_stall, s_write); end
      tick();
    end
    drive(1'b0, 1'b1, 32'h0000_4000, 4'hF);
    n_checks++; if (cpu_stall !== 1'b0 || s_write !== 1'b1) begin n_errors++; $display("FAIL stall_done got=s%b w%b exp=s0 w1", cpu_stall, s_write); end
    tick();
    drive(1'b0, 1'b0, 32'h0, 4'hF);
    n_checks++; if (cpu_fault !== 1'b0 || fault_count !== 8'(exp_cnt)) begin n_errors++; $display("FAIL stall_nofault got=f%b c%0d exp=f0 c%0d", cpu_fault, fault_count, exp_cnt); end
    $display("write-stall: addr=00004000 stalled=3");
  endtask

  task automatic test_timeout();
    for (int c = 0; c < LIMIT; c++) begin
      drive(1'b1, 1'b0, 32'h0000_4008, 4'b1011);
      n_checks++; if (cpu_stall !== 1'b1 || s_read !== 1'b0) begin n_errors++; $display("FAIL tmo_c%0d got=s%b r%b exp=s1 r0", c, cpu_stall, s_read); end
      tick();
    end
    drive(1'b1, 1'b0, 32'h0000_4008, 4'b1011);
    n_checks++; if (cpu_stall !== 1'b0 || s_read !== 1'b0 || cpu_fault !== 1'b0) begin n_errors++; $display("FAIL tmo_abort got=s%b r%b f%b exp=s0 r0 f0", cpu_stall, s_read, cpu_fault); end
    tick();
    exp_cnt++;
    drive(1'b0, 1'b0, 32'h0, 4'hF);
    n_checks++; if (cpu_fault !== 1'b1) begin n_errors++; $display("FAIL tmo_fault got=%b exp=1", cpu_fault); end
    n_checks++; if (fault_addr !== 32'h4008) begin n_errors++; $display("FAIL tmo_faddr got=%h exp=4008", fault_addr); end
    n_checks++; if (fault_count !== 8'(exp_cnt)) begin n_errors++; $display("FAIL tmo_fcount got=%0d exp=%0d", fault_count, exp_cnt); end
    tick();
    n_checks++; if (cpu_fault !== 1'b0 || cpu_rvalid !== 1'b0) begin n_errors++; $display("FAIL tmo_after got=f%b v%b exp=f0 v0", cpu_fault, cpu_rvalid); end
    $display("timeout: addr=00004008 faults=%0d", exp_cnt);
  endtask

  task automatic test_unmapped();
    drive(1'b1, 1'b0, 32'h0000_8000, 4'hF);
    n_checks++; if (s_sel !== 4'h0 || s_read !== 1'b0 || cpu_stall !== 1'b0) begin n_errors++; $display("FAIL unm_decode got=sel%b r%b s%b exp=0000 0 0", s_sel, s_read, cpu_stall); end
    tick();
    drive(1'b1, 1'b1, 32'h0000_0000, 4'hF);
    n_checks++; if (s_read !== 1'b0 || s_write !== 1'b0 || cpu_stall !== 1'b0) begin n_errors++; $display("FAIL ill_strobe got=r%b w%b s%b exp=0 0 0", s_read, s_write, cpu_stall); end
    n_checks++; if (cpu_fault !== 1'b1 || fault_addr !== 32'h8000) begin n_errors++; $display("FAIL unm_fault got=f%b a%h exp=f1 a8000", cpu_fault, fault_addr); end
    tick();
    exp_cnt += 2;
    drive(1'b0, 1'b0, 32'h0, 4'hF);
    n_checks++; if (cpu_fault !== 1'b1 || fault_addr !== 32'h0) begin n_errors++; $display("FAIL ill_fault got=f%b a%h exp=f1 a0", cpu_fault, fault_addr); end
    n_checks++; if (fault_count !== 8'(exp_cnt)) begin n_errors++; $display("FAIL ill_fcount got=%0d exp=%0d", fault_count, exp_cnt); end
    tick();
    $display("unmapped+illegal: faults=%0d", exp_cnt);
  endtask

  task automatic test_saturate();
    logic [31:0] a;
    a = 32'h0;
    for (int k = 0; k < 300; k++) begin
      a = 32'h0000_8000 + 32'(k * 4);
      drive(1'b1, 1'b0, a, 4'hF);
      if (k == 100) begin
        n_checks++; if (fault_count !== 8'((exp_cnt + k > 255) ? 255 : exp_cnt + k)) begin n_errors++; $display("FAIL sat_mid got=%0d exp=%0d", fault_count, exp_cnt + k); end
      end
      tick();
    end
    drive(1'b0, 1'b0, 32'h0, 4'hF);
    n_checks++; if (fault_count !== 8'd255) begin n_errors++; $display("FAIL sat_fcount got=%0d exp=255", fault_count); end
    n_checks++; if (fault_addr !== a || cpu_fault !== 1'b1) begin n_errors++; $display("FAIL sat_faddr got=a%h f%b exp=a%h f1", fault_addr, cpu_fault, a); end
    tick();
    exp_cnt = 255;
    $display("saturate: 300 faults count=255");
  endtask

  task automatic test_rst_wait();
    for (int c = 0; c < 3; c++) begin
      drive(1'b1, 1'b0, 32'h0000_4010, 4'b0111);
      tick();
    end
    rst = 1'b1;
    drive(1'b0, 1'b0, 32'h0, 4'hF);
    tick();
    rst = 1'b0;
    #1;
    exp_cnt = 0;
    n_checks++; if (cpu_stall !== 1'b0 || cpu_rvalid !== 1'b0 || cpu_fault !== 1'b0) begin n_errors++; $display("FAIL rstw_out got=s%b v%b f%b exp=0 0 0", cpu_stall, cpu_rvalid, cpu_fault); end
    n_checks++; if (fault_count !== 8'h0 || fault_addr !== 32'h0) begin n_errors++; $display("FAIL rstw_fault got=c%0d a%h exp=c0 a0", fault_count, fault_addr); end
    drive(1'b1, 1'b0, 32'h0000_4010, 4'b0111);
    n_checks++; if (cpu_stall !== 1'b1) begin n_errors++; $display("FAIL rstw_fresh_wait got=%b exp=1", cpu_stall); end
    // A fresh stall after reset must last the full limit, proving the counter was cleared.
    for (int c = 1; c < LIMIT; c++) begin
      tick();
      drive(1'b1, 1'b0, 32'h0000_4010, 4'b0111);
    end
    n_checks++; if (cpu_stall !== 1'b1) begin n_errors++; $display("FAIL rstw_full_wait got=%b exp=1", cpu_stall); end
    rst = 1'b1;
    drive(1'b1, 1'b0, 32'h0000_4010, 4'hF);
    n_checks++; if (s_read !== 1'b1 || s_sel !== 4'b1000) begin n_errors++; $display("FAIL rstv_strobe got=r%b sel%b exp=r1 1000", s_read, s_sel); end
    tick();
    rst = 1'b0;
    drive(1'b0, 1'b0, 32'h0, 4'hF);
    n_checks++; if (cpu_rvalid !== 1'b0 || cpu_rdata !== 32'h0) begin n_errors++; $display("FAIL rstv_rvalid got=v%b d%h exp=v0 d0", cpu_rvalid, cpu_rdata); end
    $display("reset-in-wait: state cleared");
  endtask

  task automatic test_random();
    logic [31:0] addr_tab [14] = '{32'h0, 32'h100, 32'h3FFC, 32'h3FFF, 32'h4000, 32'h4003,
                                   32'h4004, 32'h4007, 32'h4008, 32'h400F, 32'h4010,
                                   32'h4017, 32'h4018, 32'hFFFF_FFFF};
    int pend_rd, waited, win, m_count, n_tmo, n_rd;
    logic pend_fault, prev_stall, rd, wr, e_stall, e_strobe, e_fault;
    logic [31:0] a, m_faddr;
    logic [N-1:0] rdy, e_sel;
    pend_rd = -1; waited = 0; m_count = 0; n_tmo = 0; n_rd = 0;
    pend_fault = 1'b0; prev_stall = 1'b0; m_faddr = 32'h0;
    rd = 1'b0; wr = 1'b0; a = 32'h0;
    rst = 1'b1;
    drive(1'b0, 1'b0, 32'h0, 4'hF);
    tick();
    rst = 1'b0;
    for (int c = 0; c < 2000; c++) begin
      if (!prev_stall) begin
        int kind;
        kind = $urandom_range(0, 15);
        a  = ($urandom_range(0, 7) == 0) ? $urandom : addr_tab[$urandom_range(0, 13)];
        rd = (kind < 7) || (kind == 15);
        wr = (kind >= 7 && kind < 13) || (kind == 15);
        cpu_wdata = $urandom;
      end
      rdy = 4'($urandom_range(0, 15)) | 4'($urandom_range(0, 15));
      if ((c % 250) < 40) rdy[3:2] = 2'b00;
      s_rdata = {$urandom, $urandom, $urandom, $urandom};
      drive(rd, wr, a, rdy);

      n_checks++; if (cpu_rvalid !== (pend_rd >= 0)) begin n_errors++; $display("FAIL rnd_rvalid c%0d got=%b exp=%b", c, cpu_rvalid, pend_rd >= 0); end
      n_checks++; if (cpu_rdata !== ((pend_rd >= 0) ? s_rdata[pend_rd*32 +: 32] : 32'h0)) begin n_errors++; $display("FAIL rnd_rdata c%0d got=%h", c, cpu_rdata); end
      n_checks++; if (cpu_fault !== pend_fault) begin n_errors++; $display("FAIL rnd_fault c%0d got=%b exp=%b", c, cpu_fault, pend_fault); end
      n_checks++; if (fault_count !== 8'(m_count) || fault_addr !== m_faddr) begin n_errors++; $display("FAIL rnd_fstate c%0d got=c%0d a%h exp=c%0d a%h", c, fault_count, fault_addr, m_count, m_faddr); end

      win = decode(a);
      e_sel = ((rd || wr) && win >= 0) ? 4'(1 << win) : 4'h0;
      e_stall = 1'b0; e_strobe = 1'b0; e_fault = 1'b0;
      if ((rd || wr) && !(rd && wr) && win >= 0) begin
        if (rdy[win]) begin
          e_strobe = 1'b1; waited = 0;
        end else if (waited == LIMIT) begin
          e_fault = 1'b1; waited = 0; n_tmo++;
        end else begin
          e_stall = 1'b1; waited++;
        end
      end else begin
        waited = 0;
        e_fault = rd || wr;
      end

      n_checks++; if (s_sel !== e_sel) begin n_errors++; $display("FAIL rnd_sel c%0d a%h got=%b exp=%b", c, a, s_sel, e_sel); end
      n_checks++; if (s_read !== (e_strobe && rd) || s_write !== (e_strobe && wr)) begin n_errors++; $display("FAIL rnd_strobe c%0d a%h got=r%b w%b exp=r%b w%b", c, a, s_read, s_write, e_strobe && rd, e_strobe && wr); end
      n_checks++; if (cpu_stall !== e_stall) begin n_errors++; $display("FAIL rnd_stall c%0d a%h got=%b exp=%b", c, a, cpu_stall, e_stall); end
      if (win >= 0) begin
        n_checks++; if (s_offset !== a - M_BASE[win]) begin n_errors++; $display("FAIL rnd_offset c%0d a%h got=%h exp=%h", c, a, s_offset, a - M_BASE[win]); end
      end
      n_checks++; if (s_wdata !== cpu_wdata) begin n_errors++; $display("FAIL rnd_wdata c%0d got=%h exp=%h", c, s_wdata, cpu_wdata); end

      pend_rd = (e_strobe && rd) ? win : -1;
      if (e_strobe && rd) n_rd++;
      pend_fault = e_fault;
      if (e_fault) begin
        m_faddr = a;
        if (m_count < 255) m_count++;
      end
      prev_stall = e_stall;
      tick();
    end
    drive(1'b0, 1'b0, 32'h0, 4'hF);
    $display("random: 2000 cycles reads=%0d timeouts=%0d faults=%0d", n_rd, n_tmo, m_count);
  endtask

  initial begin
    test_reset();
    test_write();
    test_read();
    test_stall();
    test_timeout();
    test_unmapped();
    test_saturate();
    test_rst_wait();
    test_random();
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired errors=%0d checks=%0d", n_errors, n_checks);
    $fatal(1, "timeout");
  end

endmodule
